// File: rtl/bullets_pool.sv
// Three-slot player bullet pool: spawns on frame pulses under a shot cooldown,
// moves bullets upward each frame, and produces a registered per-pixel drawing request.
module bullets_pool #(
  parameter int          SPEED        = 4,
  parameter int          BULLET_W     = 4,
  parameter int          BULLET_H     = 8,
  parameter int          TOP_LIMIT    = 0,
  parameter int          COOLDOWN     = 8,
  parameter logic [7:0]  BULLET_COLOR = 8'hFC
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [2:0]  collision,
  output logic [2:0]  bulletDrawingRequest,
  output logic [7:0]  bulletRGB,
  output logic [2:0]  activeMask
);

  localparam int          N_SLOTS = 3;
  localparam int          CD_W    = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [11:0] EXIT_Y  = 12'(TOP_LIMIT + SPEED);

  typedef enum logic {S_IDLE = 1'b0, S_FLYING = 1'b1} slot_state_t;

  slot_state_t       r_state [N_SLOTS];
  logic [10:0]       r_x     [N_SLOTS];
  logic [10:0]       r_y     [N_SLOTS];
  logic              r_fire_pending;
  logic [CD_W-1:0]   r_cooldown;
  logic [2:0]        r_draw_req;
  logic [7:0]        r_rgb;

  logic [2:0]        w_idle;
  logic [2:0]        w_lowest_idle;
  logic [2:0]        w_spawn_sel;
  logic [2:0]        w_hit;
  logic              w_want;
  logic              w_spawn;

  // Idleness is sampled before the edge, so a slot killed this cycle is never respawned now.
  always_comb begin
    w_idle     = '0;
    activeMask = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_idle[i]     = (r_state[i] == S_IDLE);
      activeMask[i] = (r_state[i] == S_FLYING);
    end
  end

  assign w_lowest_idle = w_idle & 3'(~w_idle + 3'd1);
  assign w_want        = startOfFrame & (r_fire_pending | fire) & (r_cooldown == '0);
  assign w_spawn       = w_want & (|w_idle);
  assign w_spawn_sel   = w_spawn ? w_lowest_idle : 3'b000;

  // Edges computed in 12 bits so a bullet touching X/Y 2047 does not wrap to 0.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_hit[i] = (r_state[i] == S_FLYING)
              && ({1'b0, pixelX} >= {1'b0, r_x[i]})
              && ({1'b0, pixelX} <  ({1'b0, r_x[i]} + 12'(BULLET_W)))
              && ({1'b0, pixelY} >= {1'b0, r_y[i]})
              && ({1'b0, pixelY} <  ({1'b0, r_y[i]} + 12'(BULLET_H)));
    end
  end

  // NOTE: state registers use non-blocking assignments so every slot sees pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (collision[i] && (r_state[i] == S_FLYING)) begin
          r_state[i] <= S_IDLE;
        end else if (w_spawn_sel[i]) begin
          r_state[i] <= S_FLYING;
          r_x[i]     <= spawnX;
          r_y[i]     <= spawnY;
        end else if (startOfFrame && (r_state[i] == S_FLYING)) begin
          if ({1'b0, r_y[i]} >= EXIT_Y) r_y[i] <= r_y[i] - 11'(SPEED);
          else                           r_state[i] <= S_IDLE;
        end
      end
    end
  end

  // A dropped request (all slots busy) has cooldown already at 0, so saturation covers it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fire_pending <= 1'b0;
      r_cooldown     <= '0;
    end else begin
      if (startOfFrame)  r_fire_pending <= 1'b0;
      else if (fire)     r_fire_pending <= 1'b1;

      if (startOfFrame) begin
        if (w_spawn)                 r_cooldown <= CD_W'(COOLDOWN);
        else if (r_cooldown != '0)   r_cooldown <= r_cooldown - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_draw_req <= '0;
      r_rgb      <= 8'hFF;
    end else begin
      r_draw_req <= w_hit;
      r_rgb      <= (|w_hit) ? BULLET_COLOR : 8'hFF;
    end
  end

  assign bulletDrawingRequest = r_draw_req;
  assign bulletRGB            = r_rgb;

endmodule

// File: tb/tb_bullets_pool.sv
// Scenario bench for bullets_pool: pixel probes go through an expectation queue
// that a negedge monitor drains; slot-mask checks are made inline in each scenario.
module tb_bullets_pool;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        fire;
  logic [10:0] spawnX;
  logic [10:0] spawnY;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [2:0]  collision;
  logic [2:0]  bulletDrawingRequest;
  logic [7:0]  bulletRGB;
  logic [2:0]  activeMask;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic [2:0] req;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  bullets_pool dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .fire                 (fire),
    .spawnX               (spawnX),
    .spawnY               (spawnY),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .collision            (collision),
    .bulletDrawingRequest (bulletDrawingRequest),
    .bulletRGB            (bulletRGB),
    .activeMask           (activeMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pops an expectation when its registered result is due and compares request and colour.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      logic [7:0] exp_rgb;
      cur     = sb.pop_front();
      exp_rgb = (cur.req != 3'b000) ? 8'hFC : 8'hFF;
      total++;
      if (bulletDrawingRequest !== cur.req || bulletRGB !== exp_rgb) begin
        bad++;
        $display("FAIL %s: got req=%b rgb=%h, want req=%b rgb=%h",
                 cur.name, bulletDrawingRequest, bulletRGB, cur.req, exp_rgb);
      end
    end
  end

  task automatic frame(input logic f);
    startOfFrame = 1'b1;
    fire         = f;
    @(negedge clk);
    startOfFrame = 1'b0;
    fire         = 1'b0;
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  task automatic probe(input string nm, input int px, input int py, input logic [2:0] exp_req);
    pixelX = 11'(px);
    pixelY = 11'(py);
    sb.push_back('{due: cyc + 1, req: exp_req, name: nm});
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (activeMask !== 3'b000 || bulletDrawingRequest !== 3'b000 || bulletRGB !== 8'hFF) begin
      bad++;
      $display("FAIL reset_state: got mask=%b req=%b rgb=%h, want 000 000 ff",
               activeMask, bulletDrawingRequest, bulletRGB);
    end
    resetN = 1'b1;
  endtask

  task automatic test_spawn_move();
    apply_reset();
    spawnX = 11'd100;
    spawnY = 11'd400;
    fire_pulse();
    frame(1'b0);
    total++;
    if (activeMask !== 3'b001) begin
      bad++; $display("FAIL spawn_mask: got %b want 001", activeMask);
    end
    probe("y400_top",   101, 400, 3'b001);
    probe("y400_above", 101, 399, 3'b000);
    frame(1'b0);
    probe("y396_top",   101, 396, 3'b001);
    probe("y396_above", 101, 395, 3'b000);
    frame(1'b0);
    probe("pix_101_393", 101, 393, 3'b001);
    probe("y392_above",  101, 391, 3'b000);
    probe("y392_bottom", 101, 399, 3'b001);
    probe("y392_below",  101, 400, 3'b000);
  endtask

  task automatic test_boundaries();
    apply_reset();
    spawnX = 11'd50;
    spawnY = 11'd60;
    frame(1'b1);
    probe("x54_out", 54, 60, 3'b000);
    probe("x53_in",  53, 60, 3'b001);
    probe("x50_in",  50, 60, 3'b001);
    probe("x49_out", 49, 60, 3'b000);
    probe("y68_out", 50, 68, 3'b000);
    probe("y67_in",  50, 67, 3'b001);
    probe("y59_out", 50, 59, 3'b000);
    apply_reset();
    spawnX = 11'd2045;
    spawnY = 11'd2043;
    frame(1'b1);
    probe("edge_2047", 2047, 2047, 3'b001);
    probe("edge_orig", 2045, 2043, 3'b001);
    probe("edge_x0",   0,    2043, 3'b000);
  endtask

  task automatic test_top_exit();
    apply_reset();
    spawnX = 11'd10;
    spawnY = 11'd4;
    frame(1'b1);
    frame(1'b0);
    total++;
    if (activeMask !== 3'b001) begin
      bad++; $display("FAIL y4_still_flying: got %b want 001", activeMask);
    end
    probe("y0_top",    11, 0, 3'b001);
    probe("y0_bottom", 11, 7, 3'b001);
    probe("y0_below",  11, 8, 3'b000);
    frame(1'b0);
    total++;
    if (activeMask !== 3'b000) begin
      bad++; $display("FAIL y0_exit: got %b want 000", activeMask);
    end
    apply_reset();
    spawnY = 11'd3;
    frame(1'b1);
    probe("y3_hit", 11, 3, 3'b001);
    frame(1'b0);
    total++;
    if (activeMask !== 3'b000) begin
      bad++; $display("FAIL y3_exit: got %b want 000", activeMask);
    end
    probe("y3_gone",    11, 3,    3'b000);
    probe("y3_no_wrap", 11, 2047, 3'b000);
    probe("y3_row0",    11, 0,    3'b000);
  endtask

  task automatic test_cooldown();
    apply_reset();
    spawnX = 11'd200;
    spawnY = 11'd1000;
    for (int k = 0; k < 28; k++) begin
      logic [2:0] exp_mask;
      frame(1'b1);
      exp_mask = (k < 9) ? 3'b001 : (k < 18) ? 3'b011 : 3'b111;
      total++;
      if (activeMask !== exp_mask) begin
        bad++; $display("FAIL cooldown_frame%0d: got %b want %b", k, activeMask, exp_mask);
      end
    end
    probe("slot0_y892", 200, 892, 3'b001);
    probe("slot1_y928", 200, 928, 3'b010);
    probe("slot2_y964", 200, 964, 3'b100);
    collision = 3'b001;
    @(negedge clk);
    collision = 3'b000;
    total++;
    if (activeMask !== 3'b110) begin
      bad++; $display("FAIL kill_slot0: got %b want 110", activeMask);
    end
    frame(1'b0);
    total++;
    if (activeMask !== 3'b110) begin
      bad++; $display("FAIL dropped_not_pending: got %b want 110", activeMask);
    end
    frame(1'b1);
    total++;
    if (activeMask !== 3'b111) begin
      bad++; $display("FAIL dropped_no_reload: got %b want 111", activeMask);
    end
  endtask

  task automatic test_fire_pending();
    apply_reset();
    spawnX = 11'd20;
    spawnY = 11'd500;
    fire_pulse();
    frame(1'b0);
    fire_pulse();
    repeat (8) frame(1'b0);
    total++;
    if (activeMask !== 3'b001) begin
      bad++; $display("FAIL pending_cleared: got %b want 001", activeMask);
    end
    frame(1'b1);
    total++;
    if (activeMask !== 3'b011) begin
      bad++; $display("FAIL pending_next_spawn: got %b want 011", activeMask);
    end
  endtask

  task automatic test_collision_race();
    apply_reset();
    spawnX = 11'd400;
    spawnY = 11'd800;
    frame(1'b1);
    repeat (8) frame(1'b0);
    frame(1'b1);
    total++;
    if (activeMask !== 3'b011) begin
      bad++; $display("FAIL race_setup: got %b want 011", activeMask);
    end
    repeat (8) frame(1'b0);
    fire_pulse();
    spawnY       = 11'd600;
    startOfFrame = 1'b1;
    collision    = 3'b010;
    @(negedge clk);
    startOfFrame = 1'b0;
    collision    = 3'b000;
    total++;
    if (activeMask !== 3'b101) begin
      bad++; $display("FAIL race_mask: got %b want 101", activeMask);
    end
    probe("race_slot2", 400, 600, 3'b100);
    collision = 3'b010;
    @(negedge clk);
    collision = 3'b000;
    total++;
    if (activeMask !== 3'b101) begin
      bad++; $display("FAIL idle_collision: got %b want 101", activeMask);
    end
    collision = 3'b001;
    @(negedge clk);
    collision = 3'b000;
    total++;
    if (activeMask !== 3'b100) begin
      bad++; $display("FAIL kill_slot0_race: got %b want 100", activeMask);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    spawnX = 11'd200;
    spawnY = 11'd1000;
    repeat (19) frame(1'b1);
    total++;
    if (activeMask !== 3'b111) begin
      bad++; $display("FAIL midflight_setup: got %b want 111", activeMask);
    end
    pixelX = 11'd201;
    pixelY = 11'd928;
    @(negedge clk);
    total++;
    if (bulletDrawingRequest !== 3'b001 || bulletRGB !== 8'hFC) begin
      bad++;
      $display("FAIL pre_reset_hit: got req=%b rgb=%h, want 001 fc", bulletDrawingRequest, bulletRGB);
    end
    resetN = 1'b0;
    #1;
    total++;
    if (activeMask !== 3'b000 || bulletRGB !== 8'hFF || bulletDrawingRequest !== 3'b000) begin
      bad++;
      $display("FAIL reset_immediate: got mask=%b req=%b rgb=%h, want 000 000 ff",
               activeMask, bulletDrawingRequest, bulletRGB);
    end
    frame(1'b1);
    total++;
    if (activeMask !== 3'b000) begin
      bad++; $display("FAIL spawn_in_reset: got %b want 000", activeMask);
    end
    resetN = 1'b1;
    spawnX = 11'd300;
    spawnY = 11'd300;
    frame(1'b1);
    total++;
    if (activeMask !== 3'b001) begin
      bad++; $display("FAIL post_reset_spawn: got %b want 001", activeMask);
    end
    probe("post_reset_orig",   300, 300, 3'b001);
    probe("post_reset_corner", 303, 307, 3'b001);
    probe("post_reset_right",  304, 300, 3'b000);
  endtask

  initial begin
    startOfFrame = 1'b0;
    fire         = 1'b0;
    spawnX       = '0;
    spawnY       = '0;
    pixelX       = '0;
    pixelY       = '0;
    collision    = '0;

    test_reset();
    test_spawn_move();
    test_boundaries();
    test_top_exit();
    test_cooldown();
    test_fire_pending();
    test_collision_race();
    test_reset_midflight();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
